// File: rtl/prog_counter_if.sv
// prog_counter_if: control and status bundle of the programmable counter.
interface prog_counter_if #(parameter int WIDTH = 16, parameter int PRESCALE_WIDTH = 8);
    logic enable;
    logic dir;
    logic [1:0] mode;
    logic load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] limit;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic clear_flags;
    logic [WIDTH-1:0] count;
    logic tc;
    logic overflow;
    logic running;
    modport master (
        output enable, dir, mode, load, load_value, limit, prescale, clear_flags,
        input count, tc, overflow, running
    );
    modport slave (
        input enable, dir, mode, load, load_value, limit, prescale, clear_flags,
        output count, tc, overflow, running
    );
endinterface

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with prescaler, wrap/saturate/one-shot
// terminal behaviour, terminal-count pulse and sticky overflow.
module prog_counter #(
    parameter int WIDTH = 16,
    parameter int PRESCALE_WIDTH = 8
) (
    input logic clk,
    input logic reset,
    prog_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] one = 1;
    localparam logic [PRESCALE_WIDTH-1:0] pone = 1;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic tick;
    logic term;
    logic hold;
    logic [WIDTH-1:0] next_count;
    always_comb begin
        tick = bus.enable && bus.running && (pre_cnt >= bus.prescale);
        term = bus.dir ? (bus.count == '0) : (bus.count >= bus.limit);
        hold = (bus.mode == 2'b01) || (bus.mode == 2'b10);
        next_count = !term ? (bus.dir ? bus.count - one : bus.count + one)
                   : hold ? bus.count
                   : bus.dir ? bus.limit : '0;
    end
    // load drops a coincident tick, but clear_flags still acts on that cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.count <= '0;
            bus.tc <= 1'b0;
            bus.overflow <= 1'b0;
            bus.running <= 1'b1;
            pre_cnt <= '0;
        end else if (bus.load) begin
            bus.count <= bus.load_value;
            bus.tc <= 1'b0;
            bus.overflow <= bus.overflow && !bus.clear_flags;
            bus.running <= 1'b1;
            pre_cnt <= '0;
        end else begin
            bus.tc <= tick && term;
            bus.overflow <= (tick && term) || (bus.overflow && !bus.clear_flags);
            if (tick) begin
                bus.count <= next_count;
                pre_cnt <= '0;
                if (term && bus.mode == 2'b10) bus.running <= 1'b0;
            end else if (bus.enable && bus.running) begin
                pre_cnt <= pre_cnt + pone;
            end
        end
    end
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed stimulus with a queued scoreboard checked by a
// separate monitor one clock after each stimulus cycle.
module tb_prog_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    prog_counter_if #(.WIDTH(16), .PRESCALE_WIDTH(8)) bus ();
    prog_counter #(.WIDTH(16), .PRESCALE_WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {
        string name;
        logic [15:0] c;
        logic t;
        logic o;
        logic r;
    } exp_t;
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    logic s_dir = 1'b0;
    logic [1:0] s_mode = 2'b00;
    logic [15:0] s_lim = 16'd5;
    logic [7:0] s_ps = 8'd0;
    task automatic drive(input logic en, input logic ld, input logic [15:0] lv,
                         input logic clr, input logic rst, input string nm,
                         input logic [15:0] c, input logic t, input logic o, input logic r);
        exp_t e;
        @(negedge clk);
        bus.enable = en;
        bus.load = ld;
        bus.load_value = lv;
        bus.clear_flags = clr;
        bus.dir = s_dir;
        bus.mode = s_mode;
        bus.limit = s_lim;
        bus.prescale = s_ps;
        reset = rst;
        e.name = nm;
        e.c = c;
        e.t = t;
        e.o = o;
        e.r = r;
        q.push_back(e);
    endtask
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.count !== e.c || bus.tc !== e.t || bus.overflow !== e.o || bus.running !== e.r) begin
                    errors++;
                    $display("FAIL %s: got count=%0d tc=%b ovf=%b run=%b, want count=%0d tc=%b ovf=%b run=%b",
                             e.name, bus.count, bus.tc, bus.overflow, bus.running, e.c, e.t, e.o, e.r);
                end
            end
        end
    end
    initial begin
        bus.enable = 0; bus.load = 0; bus.load_value = 0; bus.clear_flags = 0;
        bus.dir = 0; bus.mode = 0; bus.limit = 5; bus.prescale = 0;
        // up wrap, limit 5
        drive(0, 0, 0, 0, 1, "reset", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap1", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap2", 2, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap3", 3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap4", 4, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap5", 5, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "upwrap0", 0, 1, 1, 1);
        drive(1, 0, 0, 0, 0, "upwrap1b", 1, 0, 1, 1);
        // prescale 2 with an enable gap
        s_ps = 8'd2;
        drive(0, 0, 0, 0, 1, "reset2", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e1", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e2", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, "pre_gap", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e3", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e4", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e5", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "pre_e6", 2, 0, 0, 1);
        // down saturate from 3
        s_ps = 8'd0; s_dir = 1'b1; s_mode = 2'b01; s_lim = 16'd10;
        drive(1, 1, 3, 0, 0, "dsat_load", 3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dsat2", 2, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dsat1", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dsat0", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dsat0_tc", 0, 1, 1, 1);
        drive(1, 0, 0, 0, 0, "dsat0_tc2", 0, 1, 1, 1);
        drive(0, 0, 0, 1, 0, "clear", 0, 0, 0, 1);
        // down wrap from 3
        s_mode = 2'b00;
        drive(1, 1, 3, 0, 0, "dwrap_load", 3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dwrap2", 2, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dwrap1", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dwrap0", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "dwrap10", 10, 1, 1, 1);
        drive(1, 0, 0, 0, 0, "dwrap9", 9, 0, 1, 1);
        // one-shot up to 4, then restart
        s_dir = 1'b0; s_mode = 2'b10; s_lim = 16'd4;
        drive(1, 1, 0, 1, 0, "os_load", 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "os1", 1, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "os2", 2, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "os3", 3, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "os4", 4, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "os_expire", 4, 1, 1, 0);
        drive(1, 0, 0, 0, 0, "os_frozen", 4, 0, 1, 0);
        drive(1, 0, 0, 0, 0, "os_frozen2", 4, 0, 1, 0);
        drive(1, 1, 1, 0, 0, "os_restart", 1, 0, 1, 1);
        drive(1, 0, 0, 0, 0, "os_resume", 2, 0, 1, 1);
        // load colliding with a terminal tick, then clear colliding with one
        s_mode = 2'b00;
        drive(1, 0, 0, 0, 0, "wrap3", 3, 0, 1, 1);
        drive(1, 0, 0, 0, 0, "wrap4", 4, 0, 1, 1);
        drive(1, 1, 2, 0, 0, "load_vs_tick", 2, 0, 1, 1);
        drive(1, 0, 0, 0, 0, "c3", 3, 0, 1, 1);
        drive(1, 0, 0, 0, 0, "c4", 4, 0, 1, 1);
        drive(1, 0, 0, 1, 0, "clr_vs_term", 0, 1, 1, 1);
        drive(0, 0, 0, 1, 0, "clr_only", 0, 0, 0, 1);
        // load above limit
        s_lim = 16'd5;
        drive(1, 1, 20, 0, 0, "load20", 20, 0, 0, 1);
        drive(1, 0, 0, 0, 0, "over_lim", 0, 1, 1, 1);
        // limit zero, up then down
        s_lim = 16'd0;
        drive(1, 0, 0, 0, 0, "lim0_up", 0, 1, 1, 1);
        drive(1, 0, 0, 0, 0, "lim0_up2", 0, 1, 1, 1);
        s_dir = 1'b1;
        drive(1, 0, 0, 0, 0, "lim0_down", 0, 1, 1, 1);
        // reset after one-shot expiry
        s_dir = 1'b0; s_mode = 2'b10;
        drive(1, 0, 0, 0, 0, "os0_expire", 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, "os0_idle", 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, "reset_mid", 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, "idle", 0, 0, 0, 1);
        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prog_counter.md
# prog_counter

Programmable up/down counter that succeeds the fixed 16-bit free-running counter. It adds parametrised width, a runtime terminal limit, count direction, three terminal behaviours (wrap, saturate, one-shot), an enable prescaler, a terminal-count pulse and a sticky overflow flag. It sits in the same timer/event-counting slot as its predecessor and is controlled by a register block or a local FSM.

## Interface
- WIDTH, 16, counter and limit width (≥2)
- PRESCALE_WIDTH, 8, prescaler compare width (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  qualifies prescaler advance
- dir  in  1  0 = up, 1 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- load  in  1  load load_value into count
- load_value  in  WIDTH  value loaded on load
- limit  in  WIDTH  terminal value; count range 0..limit
- prescale  in  PRESCALE_WIDTH  step once per prescale+1 enabled cycles
- clear_flags  in  1  clears overflow
- count  out  WIDTH  current count, registered
- tc  out  1  one-cycle terminal-count pulse, registered
- overflow  out  1  sticky, set on any terminal tick
- running  out  1  0 only after one-shot expiry

## Operation
- Internal prescaler pre_cnt is PRESCALE_WIDTH bits.
  - Increments when enable=1.
  - tick = enable && running && (pre_cnt >= prescale). On tick, pre_cnt returns to 0.
  - pre_cnt is held while running=0.
- Terminal condition, evaluated on the current count:
  - up: count >= limit
  - down: count == 0
- Tick when not at terminal: count ± 1.
- Tick at terminal:
  - wrap: up → 0, down → limit
  - saturate: hold
  - one-shot: hold and clear running
- tc pulses and overflow sets on every tick taken at terminal, in all modes. In saturate mode this repeats each tick while held. One-shot therefore produces exactly one tc.
- Priority, highest first: reset > load > tick.
  - load: count <= load_value, pre_cnt <= 0, running <= 1, tc <= 0. A simultaneous tick is dropped.
- clear_flags clears overflow. If a terminal tick occurs in the same cycle, set wins and overflow = 1.
- Arithmetic is modulo 2^WIDTH internally. Up-count can never exceed limit except via load_value > limit or limit lowered below count; the next up tick then treats count as terminal.
  - In down mode a count > limit decrements normally. Wrap targets limit.
- limit = 0:
  - up/wrap: count stays 0, tc on every tick
  - down/wrap: 0 → 0, tc on every tick
- dir, mode, limit and prescale are sampled every cycle. Changes take effect on the next tick with no restart.

## Timing
- Reset values: count = 0, tc = 0, overflow = 0, running = 1, pre_cnt = 0.
- Tick at edge N updates count and tc at edge N (visible in cycle N+1). tc is high for exactly that one cycle.
- With prescale = 0 and enable held high, count steps every cycle. With prescale = P, the first tick occurs P+1 enabled cycles after reset or load, then every P+1 enabled cycles.
- enable low freezes pre_cnt; there is no loss of partial prescale progress.
- load → count visible 1 cycle later. Reset mid-count fully reinitialises on the next edge.

## Test plan
- **Up wrap.** WIDTH=16, limit=5, prescale=0, enable=1, after reset. Required: count 1,2,3,4,5,0,1…; tc high only in the cycle count shows 0; overflow=1 thereafter.
- **Prescale and enable gap.** prescale=2, enable pattern 1,1,0,1,1,1. Required: first tick after the 3rd enabled cycle (count=1), second after the 6th enabled cycle.
- **Down saturate.** mode=01, dir=1, load_value=3, limit=10. Required: count 3,2,1,0,0,0; tc pulses on each tick at 0.
- **Down wrap.** Same start with mode=00. Required: count 3,2,1,0,10,9.
- **One-shot.** mode=10, up, limit=4. Required: count reaches 4, single tc, running=0, count frozen.
  - load_value=1 restarts: running=1, counting resumes.
- **Collisions.**
  - load and tick in the same cycle: count = load_value, tc = 0.
  - clear_flags with a terminal tick: overflow stays 1.
  - load_value=20 with limit=5, up: next tick gives 0 and tc.
  - reset mid-run: all outputs return to reset values.
